multi_cycle_sequencer: RTL and testbench
========================================

Name: multi_cycle_sequencer

Overview:
Main control FSM for the multi-cycle RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY, and WRITEBACK. It also gates the static decode signals from the core control unit into per-state datapath enables and handshakes with the instruction and data memories. It counts retired instructions, halts on ECALL, and flags illegal opcodes and memory timeouts.

Parameters:
XLEN, 32, datapath width (informational; no internal datapath)
MEM_TIMEOUT, 16, max request cycles waiting for a memory ready; 0 disables timeout
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  core clock
reset_n_i  in  1  asynchronous active-low reset
op_code_i  in  7  opcode of the instruction register
reg_write_enable_i  in  1  decoded register-write request
data_memory_write_enable_i  in  1  decoded store flag
pc_mux_sel_i  in  2  decoded PC source: 00 next, 01 jump, 10 branch
branch_taken_i  in  1  comparator result, valid in WRITEBACK
imem_ready_i  in  1  instruction memory ready/data valid
dmem_ready_i  in  1  data memory ready/data valid
imem_req_o  out  1  instruction fetch request
ir_write_enable_o  out  1  load instruction register
operand_latch_enable_o  out  1  latch register-file read data
alu_result_latch_enable_o  out  1  latch ALU/comparator result
dmem_req_o  out  1  data memory request
dmem_write_enable_o  out  1  data memory write strobe
reg_write_enable_o  out  1  gated register-file write
pc_write_enable_o  out  1  PC update
pc_mux_sel_o  out  2  resolved PC source
instr_retired_o  out  1  one-cycle retire pulse
retired_count_o  out  CNT_WIDTH  retired instruction count
illegal_instr_o  out  1  one-cycle illegal-opcode pulse
bus_error_o  out  1  sticky memory-timeout flag
halted_o  out  1  core halted
state_o  out  3  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5. Values 6 and 7 return to FETCH.
- Reset, asynchronous and valid at any point including mid-request:
  - state goes to FETCH, retired_count_o=0, bus_error_o=0, wait counter=0.
  - All outputs read 0 while reset is low, except state_o=0.
  - After release, imem_req_o=1.
- Output timing: outputs decode from the state register, except the ready-qualified strobes noted below. Strobes are 0 outside their state.
- FETCH:
  - imem_req_o=1.
  - On imem_ready_i=1: ir_write_enable_o=1 in that cycle, then go to DECODE.
  - Otherwise hold.
- DECODE (1 cycle):
  - operand_latch_enable_o=1.
  - Legal opcodes: 0110011, 1100011, 0100011, 1100111, 0000011, 0010011, 0001111, 1110011, 0110111, 0010111, 1101111.
  - Illegal opcode: illegal_instr_o=1, go to WRITEBACK with register write and memory suppressed. The PC still advances (pc_mux_sel_o=00).
  - Opcode 1110011 (ECALL): go to HALT; no retire pulse.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - alu_result_latch_enable_o=1.
  - Opcode 0000011 or 0100011: go to MEMORY; otherwise go to WRITEBACK.
- MEMORY:
  - dmem_req_o=1.
  - dmem_write_enable_o = data_memory_write_enable_i while in MEMORY.
  - On dmem_ready_i=1: go to WRITEBACK.
- WRITEBACK (1 cycle):
  - pc_write_enable_o=1, instr_retired_o=1, retired_count_o increments. The counter wraps modulo 2^CNT_WIDTH.
  - reg_write_enable_o = reg_write_enable_i, forced 0 for an illegal instruction.
  - pc_mux_sel_o = pc_mux_sel_i, except: 10 with branch_taken_i=0 gives 00; illegal gives 00.
  - Next state FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH or MEMORY.
  - It increments each FETCH/MEMORY cycle with ready low.
  - If ready is low when counter==MEM_TIMEOUT-1 (MEM_TIMEOUT>0): bus_error_o=1 (sticky), go to HALT, and the request drops on the next edge.
  - Ready arriving exactly on that cycle is accepted and raises no error.
- HALT: halted_o=1, all strobes 0. Only reset exits HALT.
- Latency with ready high on the first request cycle: non-memory instruction takes 4 cycles from FETCH to retire; load/store takes 5.
- Ready asserted outside the matching request state is ignored.

Test Plan:
- Reset release, imem_ready_i=1 always, ADD (op 0110011, reg_write_enable_i=1) -> states 0,1,2,4 on consecutive cycles; reg_write_enable_o=1 and instr_retired_o=1 in cycle 4; retired_count_o=1.
- LW with dmem_ready_i asserted 3 cycles after MEMORY entry -> dmem_req_o high for 4 cycles, dmem_write_enable_o=0; WRITEBACK follows; total 8 cycles.
- BEQ (pc_mux_sel_i=10) with branch_taken_i=0 then 1 -> pc_mux_sel_o=00 then 10 in WRITEBACK; reg_write_enable_o=0 both times.
- Opcode 1111111 -> illegal_instr_o pulse in DECODE; WRITEBACK has reg_write_enable_o=0, pc_mux_sel_o=00; count increments.
- MEM_TIMEOUT=16, imem_ready_i held 0 -> bus_error_o=1 and state_o=5 after 16 request cycles. Repeat with ready on cycle 16 -> no error.
- ECALL -> state_o=5, halted_o=1, count unchanged. Then reset_n_i pulse mid-MEMORY on the next program -> imem_req_o=0 and dmem_req_o=0 immediately while low; state_o=0.

Source files
------------

// File: rtl/multi_cycle_sequencer_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the core datapath/memories.
// master = sequencer side, slave = datapath/memory side.
interface multi_cycle_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           op_code_i;
  logic                 reg_write_enable_i;
  logic                 data_memory_write_enable_i;
  logic [1:0]           pc_mux_sel_i;
  logic                 branch_taken_i;
  logic                 imem_ready_i;
  logic                 dmem_ready_i;
  logic                 imem_req_o;
  logic                 ir_write_enable_o;
  logic                 operand_latch_enable_o;
  logic                 alu_result_latch_enable_o;
  logic                 dmem_req_o;
  logic                 dmem_write_enable_o;
  logic                 reg_write_enable_o;
  logic                 pc_write_enable_o;
  logic [1:0]           pc_mux_sel_o;
  logic                 instr_retired_o;
  logic [CNT_WIDTH-1:0] retired_count_o;
  logic                 illegal_instr_o;
  logic                 bus_error_o;
  logic                 halted_o;
  logic [2:0]           state_o;

  modport master (
    input  op_code_i, reg_write_enable_i, data_memory_write_enable_i, pc_mux_sel_i,
           branch_taken_i, imem_ready_i, dmem_ready_i,
    output imem_req_o, ir_write_enable_o, operand_latch_enable_o, alu_result_latch_enable_o,
           dmem_req_o, dmem_write_enable_o, reg_write_enable_o, pc_write_enable_o,
           pc_mux_sel_o, instr_retired_o, retired_count_o, illegal_instr_o, bus_error_o,
           halted_o, state_o
  );

  modport slave (
    output op_code_i, reg_write_enable_i, data_memory_write_enable_i, pc_mux_sel_i,
           branch_taken_i, imem_ready_i, dmem_ready_i,
    input  imem_req_o, ir_write_enable_o, operand_latch_enable_o, alu_result_latch_enable_o,
           dmem_req_o, dmem_write_enable_o, reg_write_enable_o, pc_write_enable_o,
           pc_mux_sel_o, instr_retired_o, retired_count_o, illegal_instr_o, bus_error_o,
           halted_o, state_o
  );
endinterface

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory
// handshakes, retire counting, ECALL halt, illegal-opcode and memory-timeout detection.
module multi_cycle_sequencer #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  multi_cycle_sequencer_if.master bus
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("multi_cycle_sequencer supports XLEN=32 only");
  end

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 illegal_q, illegal_d;
  logic                 err_set;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 timeout_hit, legal_op;

  logic imem_req, ir_we, opnd_le, alu_le, dmem_req, dmem_we, reg_we, pc_we;
  logic retire, illegal, halted;
  logic [1:0] pc_sel;

  always_comb begin
    legal_op = 1'b0;
    case (bus.op_code_i)
      7'b0110011, 7'b1100011, 7'b0100011, 7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011, 7'b0110111, 7'b0010111, 7'b1101111: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  // Last allowed wait cycle: ready on this cycle still wins, low ready here faults.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    err_set   = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    opnd_le   = 1'b0;
    alu_le    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    retire    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready_i) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        opnd_le   = 1'b1;
        illegal_d = !legal_op;
        if (!legal_op) begin
          illegal = 1'b1;
          state_d = S_WRITEBACK;
        end else if (bus.op_code_i == OP_ECALL) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_le  = 1'b1;
        wait_d  = '0;
        state_d = (bus.op_code_i == OP_LOAD || bus.op_code_i == OP_STORE) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = bus.data_memory_write_enable_i;
        if (bus.dmem_ready_i) begin
          state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        pc_we     = 1'b1;
        retire    = 1'b1;
        reg_we    = bus.reg_write_enable_i & ~illegal_q;
        // Untaken branches and illegal instructions fall through to PC+4.
        if (illegal_q || (bus.pc_mux_sel_i == 2'b10 && !bus.branch_taken_i)) pc_sel = 2'b00;
        else pc_sel = bus.pc_mux_sel_i;
        wait_d    = '0;
        illegal_d = 1'b0;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      bus.bus_error_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
      if (err_set) bus.bus_error_o <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held, including the FETCH request.
  assign bus.imem_req_o                = reset_n_i & imem_req;
  assign bus.ir_write_enable_o         = reset_n_i & ir_we;
  assign bus.operand_latch_enable_o    = reset_n_i & opnd_le;
  assign bus.alu_result_latch_enable_o = reset_n_i & alu_le;
  assign bus.dmem_req_o                = reset_n_i & dmem_req;
  assign bus.dmem_write_enable_o       = reset_n_i & dmem_we;
  assign bus.reg_write_enable_o        = reset_n_i & reg_we;
  assign bus.pc_write_enable_o         = reset_n_i & pc_we;
  assign bus.pc_mux_sel_o              = reset_n_i ? pc_sel : 2'b00;
  assign bus.instr_retired_o           = reset_n_i & retire;
  assign bus.illegal_instr_o           = reset_n_i & illegal;
  assign bus.halted_o                  = reset_n_i & halted;
  assign bus.retired_count_o           = retired_q;
  assign bus.state_o                   = state_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: instruction flows, branch resolution, illegal
// opcodes, ECALL halt, async reset mid-request and memory timeout boundary.
module tb_multi_cycle_sequencer;
  logic clk_i = 1'b0;
  logic reset_n_i;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  multi_cycle_sequencer_if #(.CNT_WIDTH(32)) bus ();

  multi_cycle_sequencer #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic rwe, input logic dwe, input logic [1:0] sel);
    bus.op_code_i                  = op;
    bus.reg_write_enable_i         = rwe;
    bus.data_memory_write_enable_i = dwe;
    bus.pc_mux_sel_i               = sel;
  endtask

  initial begin
    reset_n_i          = 1'b0;
    set_instr(7'b0110011, 1'b1, 1'b0, 2'b00);
    bus.branch_taken_i = 1'b0;
    bus.imem_ready_i   = 1'b1;
    bus.dmem_ready_i   = 1'b0;
    #1;
    chk("rst_imem_req", bus.imem_req_o, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_count", bus.retired_count_o, 0);
    chk("rst_bus_err", bus.bus_error_o, 0);
    chk("rst_ir_we", bus.ir_write_enable_o, 0);
    repeat (2) tick();
    reset_n_i = 1'b1;
    #1;
    chk("rel_imem_req", bus.imem_req_o, 1);

    // ADD: 0,1,2,4
    chk("add_ir_we", bus.ir_write_enable_o, 1);
    tick(); chk("add_s1", bus.state_o, 1); chk("add_opnd", bus.operand_latch_enable_o, 1);
    tick(); chk("add_s2", bus.state_o, 2); chk("add_alu", bus.alu_result_latch_enable_o, 1);
    tick(); chk("add_s4", bus.state_o, 4);
    chk("add_rwe", bus.reg_write_enable_o, 1);
    chk("add_ret", bus.instr_retired_o, 1);
    chk("add_pcwe", bus.pc_write_enable_o, 1);
    tick(); chk("add_s0", bus.state_o, 0); chk("add_cnt", bus.retired_count_o, 1);
    chk("add_ret_off", bus.instr_retired_o, 0);

    // LW: memory ready on the 4th MEMORY cycle, 8 cycles total
    set_instr(7'b0000011, 1'b1, 1'b0, 2'b00);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready_i = (i == 3);
      #1;
      chk("lw_state", bus.state_o, 3);
      chk("lw_dreq", bus.dmem_req_o, 1);
      chk("lw_dwe", bus.dmem_write_enable_o, 0);
      tick();
    end
    bus.dmem_ready_i = 1'b0;
    chk("lw_wb", bus.state_o, 4); chk("lw_rwe", bus.reg_write_enable_o, 1);
    chk("lw_dreq_off", bus.dmem_req_o, 0);
    tick(); chk("lw_cnt", bus.retired_count_o, 2);

    // SW with immediate ready: 5 cycles
    set_instr(7'b0100011, 1'b0, 1'b1, 2'b00);
    bus.dmem_ready_i = 1'b1;
    chk("sw_dwe_fetch", bus.dmem_write_enable_o, 0);
    repeat (3) tick();
    chk("sw_mem", bus.state_o, 3); chk("sw_dwe", bus.dmem_write_enable_o, 1);
    tick(); chk("sw_wb", bus.state_o, 4); chk("sw_rwe", bus.reg_write_enable_o, 0);
    chk("sw_dwe_wb", bus.dmem_write_enable_o, 0);
    tick(); chk("sw_cnt", bus.retired_count_o, 3);
    bus.dmem_ready_i = 1'b0;

    // BEQ untaken then taken
    set_instr(7'b1100011, 1'b0, 1'b0, 2'b10);
    bus.branch_taken_i = 1'b0;
    repeat (3) tick();
    chk("beq_nt_wb", bus.state_o, 4); chk("beq_nt_sel", bus.pc_mux_sel_o, 2'b00);
    chk("beq_nt_rwe", bus.reg_write_enable_o, 0);
    tick();
    bus.branch_taken_i = 1'b1;
    repeat (3) tick();
    chk("beq_t_sel", bus.pc_mux_sel_o, 2'b10); chk("beq_t_rwe", bus.reg_write_enable_o, 0);
    tick(); chk("beq_cnt", bus.retired_count_o, 5);
    bus.branch_taken_i = 1'b0;

    // JAL: jump select passes through
    set_instr(7'b1101111, 1'b1, 1'b0, 2'b01);
    repeat (3) tick();
    chk("jal_sel", bus.pc_mux_sel_o, 2'b01); chk("jal_rwe", bus.reg_write_enable_o, 1);
    tick();

    // Illegal opcode skips EXECUTE, suppresses write, PC falls through
    set_instr(7'b1111111, 1'b1, 1'b1, 2'b01);
    tick(); chk("ill_s1", bus.state_o, 1); chk("ill_pulse", bus.illegal_instr_o, 1);
    tick(); chk("ill_wb", bus.state_o, 4); chk("ill_rwe", bus.reg_write_enable_o, 0);
    chk("ill_sel", bus.pc_mux_sel_o, 2'b00); chk("ill_pulse_off", bus.illegal_instr_o, 0);
    chk("ill_ret", bus.instr_retired_o, 1); chk("ill_dreq", bus.dmem_req_o, 0);
    tick(); chk("ill_cnt", bus.retired_count_o, 7); chk("ill_s0", bus.state_o, 0);

    // Fetch ready on the 16th request cycle: accepted, no error
    set_instr(7'b0110011, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      bus.imem_ready_i = (i == 15);
      #1;
      if (i == 15) chk("late_ir_we", bus.ir_write_enable_o, 1);
      else chk("late_wait", bus.state_o, 0);
      tick();
    end
    chk("late_s1", bus.state_o, 1); chk("late_err", bus.bus_error_o, 0);
    repeat (3) tick();
    chk("late_cnt", bus.retired_count_o, 8);

    // ECALL halts, no retire
    set_instr(7'b1110011, 1'b0, 1'b0, 2'b00);
    repeat (2) tick();
    chk("ecall_s5", bus.state_o, 5); chk("ecall_halt", bus.halted_o, 1);
    repeat (3) tick();
    chk("ecall_stay", bus.state_o, 5); chk("ecall_cnt", bus.retired_count_o, 8);
    chk("ecall_ireq", bus.imem_req_o, 0);

    // Reset pulse, then reset again mid-MEMORY
    reset_n_i = 1'b0; #1; reset_n_i = 1'b1; #1;
    chk("rst2_s0", bus.state_o, 0);
    set_instr(7'b0000011, 1'b1, 1'b0, 2'b00);
    repeat (3) tick(); tick();
    chk("mid_mem", bus.state_o, 3);
    reset_n_i = 1'b0; #1;
    chk("mid_ireq", bus.imem_req_o, 0); chk("mid_dreq", bus.dmem_req_o, 0);
    chk("mid_state", bus.state_o, 0); chk("mid_cnt", bus.retired_count_o, 0);
    tick();
    reset_n_i = 1'b1; #1;
    chk("mid_rel_ireq", bus.imem_req_o, 1);

    // Fetch timeout after 16 request cycles
    bus.imem_ready_i = 1'b0;
    repeat (15) tick();
    chk("to_s0", bus.state_o, 0); chk("to_err0", bus.bus_error_o, 0);
    tick();
    chk("to_s5", bus.state_o, 5); chk("to_err", bus.bus_error_o, 1);
    chk("to_ireq", bus.imem_req_o, 0); chk("to_halt", bus.halted_o, 1);
    bus.imem_ready_i = 1'b1;
    repeat (2) tick();
    chk("to_sticky", bus.bus_error_o, 1); chk("to_stay", bus.state_o, 5);
    reset_n_i = 1'b0; #1;
    chk("to_rst_clr", bus.bus_error_o, 0);
    reset_n_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
